ieu_issue_queue: RTL and testbench

//  Integer issue queue feeding the IEU decode stage. Accepts dispatched integer ops (OPIMM/OP/BRANCH/LUI/AUIPC/JAL/JALR).

---
 rtl/ieu_issue_queue_if.sv | 50 +++++
 rtl/ieu_issue_queue.sv | 197 +++++++++++++++++++
 tb/tb_ieu_issue_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ieu_issue_queue_if.sv
// Dispatch / CDB / issue-bundle signal group between the dispatch stage, the
// integer issue queue and the IEU decode stage.
interface ieu_issue_queue_if #(
  parameter int unsigned NUM_CDB    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned OPC_WIDTH  = 7
);
  logic                          i_flush;
  logic                          i_dispatch_en;
  logic [OPC_WIDTH-1:0]          i_dispatch_opcode;
  logic [ADDR_WIDTH-1:0]         i_dispatch_iaddr;
  logic [DATA_WIDTH-1:0]         i_dispatch_insn;
  logic [TAG_WIDTH-1:0]          i_dispatch_tag;
  logic                          i_dispatch_rdy_a;
  logic                          i_dispatch_rdy_b;
  logic [DATA_WIDTH-1:0]         i_dispatch_src_a;
  logic [DATA_WIDTH-1:0]         i_dispatch_src_b;
  logic [TAG_WIDTH-1:0]          i_dispatch_tag_a;
  logic [TAG_WIDTH-1:0]          i_dispatch_tag_b;
  logic [NUM_CDB-1:0]            i_cdb_en;
  logic [NUM_CDB*TAG_WIDTH-1:0]  i_cdb_tag;
  logic [NUM_CDB*DATA_WIDTH-1:0] i_cdb_data;
  logic                          i_stall;
  logic                          o_full;
  logic [OPC_WIDTH-1:0]          o_opcode;
  logic [ADDR_WIDTH-1:0]         o_iaddr;
  logic [DATA_WIDTH-1:0]         o_insn;
  logic [DATA_WIDTH-1:0]         o_src_a;
  logic [DATA_WIDTH-1:0]         o_src_b;
  logic [TAG_WIDTH-1:0]          o_tag;
  logic                          o_valid;

  modport master (
    output i_flush, i_dispatch_en, i_dispatch_opcode, i_dispatch_iaddr, i_dispatch_insn,
           i_dispatch_tag, i_dispatch_rdy_a, i_dispatch_rdy_b, i_dispatch_src_a,
           i_dispatch_src_b, i_dispatch_tag_a, i_dispatch_tag_b, i_cdb_en, i_cdb_tag,
           i_cdb_data, i_stall,
    input  o_full, o_opcode, o_iaddr, o_insn, o_src_a, o_src_b, o_tag, o_valid
  );

  modport slave (
    input  i_flush, i_dispatch_en, i_dispatch_opcode, i_dispatch_iaddr, i_dispatch_insn,
           i_dispatch_tag, i_dispatch_rdy_a, i_dispatch_rdy_b, i_dispatch_src_a,
           i_dispatch_src_b, i_dispatch_tag_a, i_dispatch_tag_b, i_cdb_en, i_cdb_tag,
           i_cdb_data, i_stall,
    output o_full, o_opcode, o_iaddr, o_insn, o_src_a, o_src_b, o_tag, o_valid
  );
endinterface

// File: rtl/ieu_issue_queue.sv
// Integer issue queue: holds dispatched ops until both operands are present
// (snooping the CDBs) and issues the oldest ready op as a registered bundle.
module ieu_issue_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NUM_CDB    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned OPC_WIDTH  = 7
) (
  input logic               clk,
  input logic               n_rst,
  ieu_issue_queue_if.slave  bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_rdy_a;
  logic [DEPTH-1:0]      r_rdy_b;
  logic [OPC_WIDTH-1:0]  r_opcode [DEPTH];
  logic [ADDR_WIDTH-1:0] r_iaddr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_insn   [DEPTH];
  logic [TAG_WIDTH-1:0]  r_tag    [DEPTH];
  logic [DATA_WIDTH-1:0] r_src_a  [DEPTH];
  logic [DATA_WIDTH-1:0] r_src_b  [DEPTH];
  logic [TAG_WIDTH-1:0]  r_ptag_a [DEPTH];
  logic [TAG_WIDTH-1:0]  r_ptag_b [DEPTH];
  logic [DEPTH-1:0]      r_age    [DEPTH];
  logic                  r_full;

  logic                  r_o_valid;
  logic [OPC_WIDTH-1:0]  r_o_opcode;
  logic [ADDR_WIDTH-1:0] r_o_iaddr;
  logic [DATA_WIDTH-1:0] r_o_insn;
  logic [DATA_WIDTH-1:0] r_o_src_a;
  logic [DATA_WIDTH-1:0] r_o_src_b;
  logic [TAG_WIDTH-1:0]  r_o_tag;

  logic [DEPTH-1:0]      w_cand;
  logic [DEPTH-1:0]      w_blocked;
  logic [DEPTH-1:0]      w_pick;
  logic [DEPTH-1:0]      w_valid_nxt;
  logic [IDX_W-1:0]      w_sel;
  logic [IDX_W-1:0]      w_free;
  logic                  w_issue;
  logic                  w_disp;
  logic [DEPTH-1:0]      w_hit_a;
  logic [DEPTH-1:0]      w_hit_b;
  logic [DATA_WIDTH-1:0] w_wake_a [DEPTH];
  logic [DATA_WIDTH-1:0] w_wake_b [DEPTH];
  logic                  w_dhit_a;
  logic                  w_dhit_b;
  logic [DATA_WIDTH-1:0] w_ddata_a;
  logic [DATA_WIDTH-1:0] w_ddata_b;
  logic                  w_cdb_dup;

  // Returns {hit, data} for a producer tag; the lowest-numbered bus wins.
  function automatic logic [DATA_WIDTH:0] cdb_lookup(
    input logic [TAG_WIDTH-1:0]          tag,
    input logic [NUM_CDB-1:0]            en,
    input logic [NUM_CDB*TAG_WIDTH-1:0]  tags,
    input logic [NUM_CDB*DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH:0] res;
    res = '0;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (en[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        res = {1'b1, data[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_cand    = r_valid & r_rdy_a & r_rdy_b;
    w_blocked = '0;
    // A candidate is blocked if any other candidate is older than it.
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (w_cand[j] && r_age[j][i]) w_blocked[i] = 1'b1;
      end
    end
    w_pick = w_cand & ~w_blocked;
    w_sel  = '0;
    w_free = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_pick[i])   w_sel  = IDX_W'(i);
      if (!r_valid[i]) w_free = IDX_W'(i);
    end
    w_issue = (|w_cand) && !bus.i_stall && !bus.i_flush;
    w_disp  = bus.i_dispatch_en && !r_full && !bus.i_flush;

    w_valid_nxt = r_valid;
    if (w_issue)     w_valid_nxt[w_sel]  = 1'b0;
    if (w_disp)      w_valid_nxt[w_free] = 1'b1;
    if (bus.i_flush) w_valid_nxt         = '0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      {w_hit_a[i], w_wake_a[i]} = cdb_lookup(r_ptag_a[i], bus.i_cdb_en, bus.i_cdb_tag, bus.i_cdb_data);
      {w_hit_b[i], w_wake_b[i]} = cdb_lookup(r_ptag_b[i], bus.i_cdb_en, bus.i_cdb_tag, bus.i_cdb_data);
    end
    {w_dhit_a, w_ddata_a} = cdb_lookup(bus.i_dispatch_tag_a, bus.i_cdb_en, bus.i_cdb_tag, bus.i_cdb_data);
    {w_dhit_b, w_ddata_b} = cdb_lookup(bus.i_dispatch_tag_b, bus.i_cdb_en, bus.i_cdb_tag, bus.i_cdb_data);

    w_cdb_dup = 1'b0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      for (int l = k + 1; l < int'(NUM_CDB); l++) begin
        if (bus.i_cdb_en[k] && bus.i_cdb_en[l] &&
            (bus.i_cdb_tag[k*TAG_WIDTH +: TAG_WIDTH] == bus.i_cdb_tag[l*TAG_WIDTH +: TAG_WIDTH]))
          w_cdb_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid    <= '0;
      r_rdy_a    <= '0;
      r_rdy_b    <= '0;
      r_full     <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_opcode <= '0;
      r_o_iaddr  <= '0;
      r_o_insn   <= '0;
      r_o_src_a  <= '0;
      r_o_src_b  <= '0;
      r_o_tag    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_opcode[i] <= '0;
        r_iaddr[i]  <= '0;
        r_insn[i]   <= '0;
        r_tag[i]    <= '0;
        r_src_a[i]  <= '0;
        r_src_b[i]  <= '0;
        r_ptag_a[i] <= '0;
        r_ptag_b[i] <= '0;
        r_age[i]    <= '0;
      end
    end else begin
      r_valid   <= w_valid_nxt;
      r_full    <= &w_valid_nxt;
      r_o_valid <= w_issue;

      for (int i = 0; i < int'(DEPTH); i++) begin
        if (r_valid[i] && !r_rdy_a[i] && w_hit_a[i]) begin
          r_rdy_a[i] <= 1'b1;
          r_src_a[i] <= w_wake_a[i];
        end
        if (r_valid[i] && !r_rdy_b[i] && w_hit_b[i]) begin
          r_rdy_b[i] <= 1'b1;
          r_src_b[i] <= w_wake_b[i];
        end
      end

      if (w_disp) begin
        r_opcode[w_free] <= bus.i_dispatch_opcode;
        r_iaddr[w_free]  <= bus.i_dispatch_iaddr;
        r_insn[w_free]   <= bus.i_dispatch_insn;
        r_tag[w_free]    <= bus.i_dispatch_tag;
        r_ptag_a[w_free] <= bus.i_dispatch_tag_a;
        r_ptag_b[w_free] <= bus.i_dispatch_tag_b;
        r_rdy_a[w_free]  <= bus.i_dispatch_rdy_a || w_dhit_a;
        r_rdy_b[w_free]  <= bus.i_dispatch_rdy_b || w_dhit_b;
        r_src_a[w_free]  <= bus.i_dispatch_rdy_a ? bus.i_dispatch_src_a : w_ddata_a;
        r_src_b[w_free]  <= bus.i_dispatch_rdy_b ? bus.i_dispatch_src_b : w_ddata_b;
      end

      // New entry is younger than every live entry and older than none.
      if (bus.i_flush) begin
        for (int i = 0; i < int'(DEPTH); i++) r_age[i] <= '0;
      end else if (w_disp) begin
        r_age[w_free] <= '0;
        for (int j = 0; j < int'(DEPTH); j++) r_age[j][w_free] <= r_valid[j];
      end

      if (w_issue) begin
        r_o_opcode <= r_opcode[w_sel];
        r_o_iaddr  <= r_iaddr[w_sel];
        r_o_insn   <= r_insn[w_sel];
        r_o_src_a  <= r_src_a[w_sel];
        r_o_src_b  <= r_src_b[w_sel];
        r_o_tag    <= r_tag[w_sel];
      end
    end
  end

  assign bus.o_full   = r_full;
  assign bus.o_valid  = r_o_valid;
  assign bus.o_opcode = r_o_opcode;
  assign bus.o_iaddr  = r_o_iaddr;
  assign bus.o_insn   = r_o_insn;
  assign bus.o_src_a  = r_o_src_a;
  assign bus.o_src_b  = r_o_src_b;
  assign bus.o_tag    = r_o_tag;

  a_cdb_unique_tag: assert property (@(posedge clk) disable iff (!n_rst) !w_cdb_dup);
endmodule

// File: tb/tb_ieu_issue_queue.sv
// Randomized scoreboard bench for ieu_issue_queue against an age-ordered list model.
module tb_ieu_issue_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCDB  = 2;
  localparam int unsigned BW    = 141;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  ieu_issue_queue_if #(.NUM_CDB(NCDB), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6), .OPC_WIDTH(7)) bus ();

  ieu_issue_queue #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                    .TAG_WIDTH(6), .OPC_WIDTH(7)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct {
    logic [6:0]  opc;
    logic [31:0] iaddr;
    logic [31:0] insn;
    logic [5:0]  tag;
    logic        rdy_a;
    logic [31:0] src_a;
    logic [5:0]  ptag_a;
    logic        rdy_b;
    logic [31:0] src_b;
    logic [5:0]  ptag_b;
  } ent_t;

  typedef struct {
    int            stamp;
    logic [BW-1:0] bundle;
  } exp_t;

  ent_t          model[$];
  exp_t          expq[$];
  logic [BW-1:0] last_bundle = '0;
  int            checks = 0;
  int            errors = 0;
  int            edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic        d_en, d_rdy_a, d_rdy_b, stall, flush;
  logic [6:0]  d_opc;
  logic [31:0] d_iaddr, d_insn, d_src_a, d_src_b;
  logic [5:0]  d_tag, d_ptag_a, d_ptag_b;
  logic        c_en   [NCDB];
  logic [5:0]  c_tag  [NCDB];
  logic [31:0] c_data [NCDB];

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    d_en = 0; d_opc = 0; d_iaddr = 0; d_insn = 0; d_tag = 0;
    d_rdy_a = 0; d_src_a = 0; d_ptag_a = 0; d_rdy_b = 0; d_src_b = 0; d_ptag_b = 0;
    stall = 0; flush = 0;
    for (int k = 0; k < NCDB; k++) begin c_en[k] = 0; c_tag[k] = 0; c_data[k] = 0; end
  endtask

  task automatic op(input logic [5:0] tag, input logic ra, input logic [31:0] sa,
                    input logic [5:0] pa, input logic rb, input logic [31:0] sb);
    d_en = 1; d_opc = 7'h13; d_iaddr = 32'h1000 + 32'(tag) * 4; d_insn = $urandom; d_tag = tag;
    d_rdy_a = ra; d_src_a = sa; d_ptag_a = pa; d_rdy_b = rb; d_src_b = sb; d_ptag_b = 6'd63;
  endtask

  task automatic randomize_inputs();
    d_en = ($urandom_range(0, 3) != 0);
    d_opc = 7'($urandom); d_iaddr = $urandom & ~32'h3; d_insn = $urandom;
    d_tag = 6'($urandom_range(0, 63));
    d_rdy_a = 1'($urandom_range(0, 1)); d_src_a = $urandom; d_ptag_a = 6'($urandom_range(8, 15));
    d_rdy_b = 1'($urandom_range(0, 1)); d_src_b = $urandom; d_ptag_b = 6'($urandom_range(8, 15));
    for (int k = 0; k < NCDB; k++) begin
      c_en[k] = ($urandom_range(0, 2) == 0);
      c_tag[k] = 6'($urandom_range(8, 15));
      c_data[k] = $urandom;
    end
    if (c_en[0] && c_en[1] && c_tag[0] == c_tag[1]) c_en[1] = 0;
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 39) == 0);
  endtask

  task automatic drive();
    bus.i_flush = flush; bus.i_stall = stall;
    bus.i_dispatch_en = d_en; bus.i_dispatch_opcode = d_opc;
    bus.i_dispatch_iaddr = d_iaddr; bus.i_dispatch_insn = d_insn; bus.i_dispatch_tag = d_tag;
    bus.i_dispatch_rdy_a = d_rdy_a; bus.i_dispatch_src_a = d_src_a; bus.i_dispatch_tag_a = d_ptag_a;
    bus.i_dispatch_rdy_b = d_rdy_b; bus.i_dispatch_src_b = d_src_b; bus.i_dispatch_tag_b = d_ptag_b;
    bus.i_cdb_en = {c_en[1], c_en[0]};
    bus.i_cdb_tag = {c_tag[1], c_tag[0]};
    bus.i_cdb_data = {c_data[1], c_data[0]};
  endtask

  task automatic wake(inout logic rdy, inout logic [31:0] src, input logic [5:0] ptag);
    for (int k = 0; k < NCDB; k++) begin
      if (!rdy && c_en[k] && c_tag[k] == ptag) begin rdy = 1; src = c_data[k]; end
    end
  endtask

  // Reference: entries kept oldest-first; the edge issues the first ready one.
  task automatic model_step();
    bit   was_full;
    int   idx;
    ent_t e;
    exp_t x;
    was_full = (model.size() == DEPTH);
    if (flush) begin
      model.delete();
    end else begin
      idx = -1;
      for (int i = 0; i < model.size(); i++)
        if (idx < 0 && model[i].rdy_a && model[i].rdy_b) idx = i;
      if (idx >= 0 && !stall) begin
        e = model[idx];
        x.stamp = edge_cnt + 1;
        x.bundle = {e.tag, e.opc, e.iaddr, e.insn, e.src_a, e.src_b};
        expq.push_back(x);
        model.delete(idx);
      end
      for (int i = 0; i < model.size(); i++) begin
        e = model[i];
        wake(e.rdy_a, e.src_a, e.ptag_a);
        wake(e.rdy_b, e.src_b, e.ptag_b);
        model[i] = e;
      end
      if (d_en && !was_full) begin
        e = '{d_opc, d_iaddr, d_insn, d_tag, d_rdy_a, d_src_a, d_ptag_a, d_rdy_b, d_src_b, d_ptag_b};
        wake(e.rdy_a, e.src_a, e.ptag_a);
        wake(e.rdy_b, e.src_b, e.ptag_b);
        model.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("o_full", 160'(bus.o_full), 160'(model.size() == DEPTH));
    drive();
    model_step();
  endtask

  task automatic idle_steps(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every issued bundle must match the scoreboard head at the expected edge.
  initial begin
    exp_t x;
    logic [BW-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (n_rst) begin
        got = {bus.o_tag, bus.o_opcode, bus.o_iaddr, bus.o_insn, bus.o_src_a, bus.o_src_b};
        if (bus.o_valid) begin
          if (expq.size() == 0) begin
            check("unexpected_issue", 160'(got), 160'(0));
            if (got == '0) begin errors++; $display("FAIL unexpected_issue: got valid expected none"); end
          end else begin
            x = expq.pop_front();
            check("issue_cycle", 160'(edge_cnt), 160'(x.stamp));
            check("issue_bundle", 160'(got), 160'(x.bundle));
            last_bundle = x.bundle;
          end
        end else begin
          if (expq.size() > 0 && expq[0].stamp <= edge_cnt) begin
            x = expq.pop_front();
            check("missing_issue", 160'(0), 160'(x.bundle));
          end
          check("bundle_hold", 160'(got), 160'(last_bundle));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    drive();
    repeat (2) @(negedge clk);
    check("reset_state", 160'({bus.o_valid, bus.o_full, bus.o_tag, bus.o_opcode, bus.o_iaddr,
                               bus.o_insn, bus.o_src_a, bus.o_src_b}), 160'(0));
    n_rst = 1;

    // ADDI, both sources ready
    idle(); op(6'd3, 1, 32'd5, 6'd0, 1, 32'd0); step();
    idle_steps(4);

    // source A woken by CDB
    idle(); op(6'd4, 0, 32'd0, 6'd7, 1, 32'd11); step();
    idle_steps(2);
    idle(); c_en[0] = 1; c_tag[0] = 6'd7; c_data[0] = 32'hABCD; step();
    idle_steps(4);

    // in-order issue with the oldest blocked
    idle(); op(6'd1, 0, 32'd0, 6'd10, 1, 32'd1); step();
    idle(); op(6'd2, 1, 32'd2, 6'd0, 1, 32'd2); step();
    idle(); op(6'd3, 1, 32'd3, 6'd0, 1, 32'd3); step();
    idle_steps(3);
    idle(); c_en[1] = 1; c_tag[1] = 6'd10; c_data[1] = 32'h1111; step();
    idle_steps(4);

    // fill to full, drop the fifth, then release all
    for (int i = 0; i < 5; i++) begin
      idle(); op(6'(20 + i), 0, 32'd0, 6'd9, 1, 32'(i)); step();
    end
    idle_steps(1);
    idle(); c_en[0] = 1; c_tag[0] = 6'd9; c_data[0] = 32'h9999; step();
    idle_steps(7);

    // stall with two ready entries
    idle(); stall = 1; op(6'd30, 1, 32'd30, 6'd0, 1, 32'd0); step();
    idle(); stall = 1; op(6'd31, 1, 32'd31, 6'd0, 1, 32'd0); step();
    idle(); stall = 1; for (int i = 0; i < 3; i++) step();
    idle_steps(4);

    // flush with three waiting entries and a same-cycle dispatch
    for (int i = 0; i < 3; i++) begin
      idle(); op(6'(40 + i), 0, 32'd0, 6'd11, 1, 32'd0); step();
    end
    idle(); op(6'd43, 1, 32'd1, 6'd0, 1, 32'd1); flush = 1; step();
    idle(); c_en[0] = 1; c_tag[0] = 6'd11; c_data[0] = 32'h5; step();
    idle_steps(4);

    for (int i = 0; i < 2000; i++) begin randomize_inputs(); step(); end

    // asynchronous reset mid-operation
    @(negedge clk);
    #2 n_rst = 0;
    #1 check("async_reset", 160'({bus.o_valid, bus.o_full, bus.o_tag, bus.o_opcode, bus.o_iaddr,
                                  bus.o_insn, bus.o_src_a, bus.o_src_b}), 160'(0));
    model.delete();
    expq.delete();
    last_bundle = '0;
    idle();
    drive();
    @(negedge clk);
    n_rst = 1;

    for (int i = 0; i < 500; i++) begin randomize_inputs(); step(); end

    idle(); flush = 1; step();
    idle_steps(4);
    check("scoreboard_drained", 160'(expq.size()), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
